// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped write-through data cache.
package cache_pkg;

    // Controller states: idle/lookup, line fill from memory, write-through.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    // One word per line: two byte-offset bits, SET_BITS index bits, rest tag.
    function automatic int index_width(input int set_bits);
        return set_bits;
    endfunction

    function automatic int tag_width(input int data_width, input int set_bits);
        return data_width - set_bits - 2;
    endfunction

    localparam int CACHE_DATA_WIDTH = 32;
    localparam int CACHE_SET_BITS   = 3;
    localparam int CACHE_INDEX_BITS = index_width(CACHE_SET_BITS);
    localparam int CACHE_TAG_BITS   = tag_width(CACHE_DATA_WIDTH, CACHE_SET_BITS);
    localparam int CACHE_SETS       = 1 << CACHE_SET_BITS;

endpackage

// File: rtl/cache_array.sv
// Tag/valid/data storage: combinational lookup, one synchronous write port,
// single-cycle invalidate-all. Only the valid bits are reset.
module cache_array
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SET_BITS   = 3
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        flush_i,
    input  logic [SET_BITS-1:0]                         rd_idx_i,
    input  logic [tag_width(DATA_WIDTH, SET_BITS)-1:0]  rd_tag_i,
    output logic                                        rd_hit_o,
    output logic [DATA_WIDTH-1:0]                       rd_data_o,
    input  logic                                        wr_en_i,
    input  logic [SET_BITS-1:0]                         wr_idx_i,
    input  logic [tag_width(DATA_WIDTH, SET_BITS)-1:0]  wr_tag_i,
    input  logic [DATA_WIDTH-1:0]                       wr_data_i
);

    localparam int TAG_W = tag_width(DATA_WIDTH, SET_BITS);
    localparam int SETS  = 1 << SET_BITS;

    logic [SETS-1:0]       r_valid;
    logic [TAG_W-1:0]      r_tag  [SETS];
    logic [DATA_WIDTH-1:0] r_data [SETS];

    assign rd_hit_o  = r_valid[rd_idx_i] && (r_tag[rd_idx_i] == rd_tag_i);
    assign rd_data_o = r_data[rd_idx_i];

    // Valid bits: cleared by reset or flush, set by a line write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (flush_i) begin
            r_valid <= '0;
        end else if (wr_en_i) begin
            r_valid[wr_idx_i] <= 1'b1;
        end
    end

    // Tag and data storage, deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            r_tag[wr_idx_i]  <= wr_tag_i;
            r_data[wr_idx_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, one-word-per-line, write-through / no-write-allocate data
// cache sitting in the memory stage. Read hits are zero-latency; misses and
// all stores stall the pipeline while the backing memory is accessed.
module data_cache
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SET_BITS   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  flush_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  stall_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ready_i
);

    localparam int TAG_W = tag_width(DATA_WIDTH, SET_BITS);
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

    state_t                r_state;
    logic                  r_flush_pending;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [DATA_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;

    logic                  w_idle;
    logic                  w_flush_now;
    logic                  w_flush_all;
    logic [SET_BITS-1:0]   w_lookup_idx;
    logic [TAG_W-1:0]      w_lookup_tag;
    logic                  w_hit;
    logic [DATA_WIDTH-1:0] w_hit_data;
    logic                  w_read_hit;
    logic                  w_wr_en;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic                  w_stall;

    assign w_idle      = (r_state == IDLE);
    // A pending flush counts as a fresh flush request on the first idle cycle.
    assign w_flush_now = flush_i | r_flush_pending;
    assign w_flush_all = w_idle & w_flush_now;

    // While busy, look up the latched address so mem_* and the array update
    // never depend on inputs that may wander during the stall.
    assign w_lookup_idx = w_idle ? addr_i[SET_BITS+1:2]
                                 : r_mem_addr[SET_BITS+1:2];
    assign w_lookup_tag = w_idle ? addr_i[DATA_WIDTH-1:SET_BITS+2]
                                 : r_mem_addr[DATA_WIDTH-1:SET_BITS+2];

    // Fills always write; a store only refreshes the line it already hits.
    assign w_wr_en   = mem_ready_i & ((r_state == FILL) | ((r_state == WRITE) & w_hit));
    assign w_wr_data = (r_state == FILL) ? mem_rdata_i : r_mem_wdata;

    cache_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .SET_BITS   (SET_BITS)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (w_flush_all),
        .rd_idx_i  (w_lookup_idx),
        .rd_tag_i  (w_lookup_tag),
        .rd_hit_o  (w_hit),
        .rd_data_o (w_hit_data),
        .wr_en_i   (w_wr_en),
        .wr_idx_i  (r_mem_addr[SET_BITS+1:2]),
        .wr_tag_i  (r_mem_addr[DATA_WIDTH-1:SET_BITS+2]),
        .wr_data_i (w_wr_data)
    );

    assign w_read_hit = w_idle & req_i & ~we_i & w_hit & ~w_flush_now;

    // Stall: idle misses/stores/flush-with-request; whole fill; write until ready.
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            IDLE:    w_stall = req_i & (w_flush_now | we_i | ~w_hit);
            FILL:    w_stall = 1'b1;
            WRITE:   w_stall = ~mem_ready_i;
            default: w_stall = 1'b0;
        endcase
    end

    assign stall_o     = w_stall & ~rst;
    assign rdata_o     = (w_read_hit & ~rst) ? w_hit_data : '0;
    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;

    // Controller FSM with registered backing-memory outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= IDLE;
            r_flush_pending <= 1'b0;
            r_mem_req       <= 1'b0;
            r_mem_we        <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wdata     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_flush_now) begin
                        // The array clears this edge; any request retries next cycle.
                        r_flush_pending <= 1'b0;
                    end else if (req_i && (we_i || !w_hit)) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= we_i;
                        r_mem_addr  <= addr_i & ALIGN_MASK;
                        r_mem_wdata <= wdata_i;
                        r_state     <= we_i ? WRITE : FILL;
                    end
                end
                FILL, WRITE: begin
                    if (flush_i) begin
                        r_flush_pending <= 1'b1;
                    end
                    if (mem_ready_i) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: a transaction-level cache/memory model
// predicts every output on every cycle of each access.
module tb_data_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        flush_i;
    logic [31:0] rdata_o;
    logic        stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ready_i;

    always #5 clk = ~clk;

    data_cache #(.DATA_WIDTH(32), .SET_BITS(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .flush_i     (flush_i),
        .rdata_o     (rdata_o),
        .stall_o     (stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ready_i (mem_ready_i)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Backing memory model and counters.
    logic [31:0] mem [logic [31:0]];
    int          lat = 3;
    int          mcnt = 0;
    int          n_reads = 0;
    int          n_writes = 0;
    logic        force_ready = 1'b0;

    // Cache model: per set, which word address it holds and the word.
    bit          mv    [8];
    logic [29:0] mword [8];
    logic [31:0] mdata [8];
    bit          flush_pend = 1'b0;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic int set_of(input logic [31:0] a);
        return int'((a >> 2) & 32'd7);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return mv[set_of(a)] && (mword[set_of(a)] == a[31:2]);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) mv[i] = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: ready after 'lat' requesting cycles, one cycle wide.
    always @(negedge clk) begin
        if (mem_req_o === 1'b1 && rst === 1'b0) begin
            mcnt = mcnt + 1;
            if (mcnt >= lat) begin
                mem_ready_i = 1'b1;
                mem_rdata_i = mem_read(mem_addr_o);
                if (mem_we_o) begin
                    mem[mem_addr_o] = mem_wdata_o;
                    n_writes++;
                end else begin
                    n_reads++;
                end
                mcnt = 0;
            end else begin
                mem_ready_i = force_ready;
            end
        end else begin
            mcnt = 0;
            mem_ready_i = force_ready;
            mem_rdata_i = 32'hBAD0_BAD0;
        end
    end

    // One cycle with no request: outputs quiet.
    task automatic idle_cycle();
        req_i = 1'b0;
        @(negedge clk); #1;
        if (flush_pend) begin
            model_clear();
            flush_pend = 1'b0;
        end
        chk("idle_stall", {31'd0, stall_o}, 32'd0);
        chk("idle_memreq", {31'd0, mem_req_o}, 32'd0);
        chk("idle_rdata", rdata_o, 32'd0);
        @(posedge clk); #1;
    endtask

    // Present one access and hold it until the pipeline is released,
    // checking every cycle against the model.
    task automatic access(input bit we, input logic [31:0] a, input logic [31:0] wd,
                          input int flush_at, output bit missed, output int stalls,
                          output logic [31:0] last_rdata);
        int  cyc;
        bit  busy;
        bit  done;
        missed = 1'b0;
        stalls = 0;
        last_rdata = 32'd0;
        busy = 1'b0;
        done = 1'b0;
        cyc = 0;
        req_i = 1'b1; we_i = we; addr_i = a; wdata_i = wd;
        while (!done && cyc < 60) begin
            flush_i = (cyc == flush_at);
            @(negedge clk); #1;
            if (stall_o === 1'b1) stalls++;
            if (!busy) begin
                if (flush_i || flush_pend) begin
                    chk("flush_stall", {31'd0, stall_o}, 32'd1);
                    chk("flush_memreq", {31'd0, mem_req_o}, 32'd0);
                    chk("flush_rdata", rdata_o, 32'd0);
                    model_clear();
                    flush_pend = 1'b0;
                end else if (!we && model_hit(a)) begin
                    chk("hit_stall", {31'd0, stall_o}, 32'd0);
                    chk("hit_rdata", rdata_o, mdata[set_of(a)]);
                    chk("hit_memreq", {31'd0, mem_req_o}, 32'd0);
                    last_rdata = rdata_o;
                    done = 1'b1;
                end else begin
                    chk("start_stall", {31'd0, stall_o}, 32'd1);
                    chk("start_rdata", rdata_o, 32'd0);
                    chk("start_memreq", {31'd0, mem_req_o}, 32'd0);
                    missed = 1'b1;
                    busy = 1'b1;
                end
            end else begin
                if (flush_i) flush_pend = 1'b1;
                chk("busy_memreq", {31'd0, mem_req_o}, 32'd1);
                chk("busy_memwe", {31'd0, mem_we_o}, {31'd0, we});
                chk("busy_memaddr", mem_addr_o, a & 32'hFFFF_FFFC);
                if (we) chk("busy_memwdata", mem_wdata_o, wd);
                chk("busy_rdata", rdata_o, 32'd0);
                if (we) begin
                    chk("write_stall", {31'd0, stall_o}, {31'd0, ~mem_ready_i});
                    if (mem_ready_i) begin
                        if (model_hit(a)) mdata[set_of(a)] = wd;
                        done = 1'b1;
                    end
                end else begin
                    chk("fill_stall", {31'd0, stall_o}, 32'd1);
                    if (mem_ready_i) begin
                        mv[set_of(a)]    = 1'b1;
                        mword[set_of(a)] = a[31:2];
                        mdata[set_of(a)] = mem_read(a & 32'hFFFF_FFFC);
                        busy = 1'b0;
                    end
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        flush_i = 1'b0;
        req_i = 1'b0;
        if (!done) chk("access_timeout", 32'd0, 32'd1);
        $display("access we=%0d addr=0x%08h wdata=0x%08h missed=%0d stalls=%0d rdata=0x%08h",
                 we, a, wd, missed, stalls, last_rdata);
    endtask

    initial begin
        bit          missed;
        int          stalls;
        logic [31:0] rd;
        int          r0;
        int          w0;

        rst = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; flush_i = 1'b0;
        mem_ready_i = 1'b0; mem_rdata_i = '0;
        model_clear();
        mem[32'h40] = 32'hDEAD_BEEF;
        #1;
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_memreq", {31'd0, mem_req_o}, 32'd0);
        chk("rst_memaddr", mem_addr_o, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle_cycle();

        // Cold load miss: 4 stall cycles, one read, then DEADBEEF.
        r0 = n_reads;
        access(1'b0, 32'h40, 32'h0, -1, missed, stalls, rd);
        chk("s1_missed", {31'd0, missed}, 32'd1);
        chk("s1_stalls", stalls, 32'd4);
        chk("s1_reads", n_reads - r0, 32'd1);
        chk("s1_rdata", rd, 32'hDEAD_BEEF);
        idle_cycle();

        // Hit, store-hit write-through, hit returns the new word.
        r0 = n_reads;
        access(1'b0, 32'h40, 32'h0, -1, missed, stalls, rd);
        chk("s2_hit", {31'd0, missed}, 32'd0);
        w0 = n_writes;
        access(1'b1, 32'h40, 32'h1234_5678, -1, missed, stalls, rd);
        chk("s2_writes", n_writes - w0, 32'd1);
        access(1'b0, 32'h42, 32'h0, -1, missed, stalls, rd);
        chk("s2_rdata", rd, 32'h1234_5678);
        chk("s2_noread", n_reads - r0, 32'd0);
        idle_cycle();

        // Conflict eviction on set 0.
        access(1'b0, 32'h60, 32'h0, -1, missed, stalls, rd);
        chk("s3_miss60", {31'd0, missed}, 32'd1);
        access(1'b0, 32'h40, 32'h0, -1, missed, stalls, rd);
        chk("s3_miss40", {31'd0, missed}, 32'd1);
        chk("s3_rdata", rd, 32'h1234_5678);

        // Store miss does not allocate; memory still updated.
        lat = 1;
        access(1'b1, 32'h80, 32'hAABB_CCDD, -1, missed, stalls, rd);
        access(1'b0, 32'h80, 32'h0, -1, missed, stalls, rd);
        chk("s4_miss80", {31'd0, missed}, 32'd1);
        chk("s4_rdata", rd, 32'hAABB_CCDD);
        idle_cycle();

        // Flush during a fill: the fill finishes, then everything is invalid.
        lat = 2;
        access(1'b0, 32'h24, 32'h0, 1, missed, stalls, rd);
        chk("s5_rdata24", rd, 32'h5A5A_0024);
        access(1'b0, 32'h80, 32'h0, -1, missed, stalls, rd);
        chk("s5_miss80", {31'd0, missed}, 32'd1);

        // Flush in idle beats a same-cycle hit, which then misses.
        access(1'b0, 32'h80, 32'h0, 0, missed, stalls, rd);
        chk("s6_miss", {31'd0, missed}, 32'd1);
        idle_cycle();

        // Reset in the middle of a fill, late ready afterwards.
        lat = 10;
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h100;
        @(posedge clk); #1;
        @(negedge clk); #1;
        chk("s7_fill_req", {31'd0, mem_req_o}, 32'd1);
        rst = 1'b1;
        #1;
        chk("s7_stall", {31'd0, stall_o}, 32'd0);
        chk("s7_memreq", {31'd0, mem_req_o}, 32'd0);
        chk("s7_memaddr", mem_addr_o, 32'd0);
        chk("s7_rdata", rdata_o, 32'd0);
        req_i = 1'b0;
        model_clear();
        flush_pend = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        force_ready = 1'b1;
        @(negedge clk); #1;
        chk("s7_late_stall", {31'd0, stall_o}, 32'd0);
        chk("s7_late_memreq", {31'd0, mem_req_o}, 32'd0);
        @(posedge clk); #1;
        force_ready = 1'b0;
        idle_cycle();
        lat = 3;
        access(1'b0, 32'h100, 32'h0, -1, missed, stalls, rd);
        chk("s7_miss100", {31'd0, missed}, 32'd1);
        access(1'b0, 32'h80, 32'h0, -1, missed, stalls, rd);
        chk("s7_miss80", {31'd0, missed}, 32'd1);
        idle_cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 The block SHALL provide parameter DATA_WIDTH, default 32, the width of data words and addresses.
REQ-002 The block SHALL provide parameter SET_BITS, default 3, the log2 of the number of sets (default 8 sets).
REQ-003 The block SHALL provide port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL provide port rst, input, 1 bit, the reset; asynchronous and active-high.
REQ-005 The block SHALL provide port req_i, input, 1 bit, a memory-stage access request this cycle.
REQ-006 The block SHALL provide port we_i, input, 1 bit, 1 = store, 0 = load.
REQ-007 The block SHALL provide port addr_i, input, DATA_WIDTH bits, the byte address from ALUResultM.
REQ-008 The block SHALL provide port wdata_i, input, DATA_WIDTH bits, the store data.
REQ-009 The block SHALL provide port flush_i, input, 1 bit, an invalidate-all request.
REQ-010 The block SHALL provide port rdata_o, output, DATA_WIDTH bits, the load data.
REQ-011 The block SHALL provide port stall_o, output, 1 bit, freezes all pipeline stages while high.
REQ-012 The block SHALL provide port mem_req_o, output, 1 bit, a backing-memory request.
REQ-013 The block SHALL provide port mem_we_o, output, 1 bit, the backing-memory write strobe.
REQ-014 The block SHALL provide port mem_addr_o, output, DATA_WIDTH bits, the word-aligned backing-memory address.
REQ-015 The block SHALL provide port mem_wdata_o, output, DATA_WIDTH bits, the backing-memory write data.
REQ-016 The block SHALL provide port mem_rdata_i, input, DATA_WIDTH bits, the backing-memory read data.
REQ-017 The block SHALL provide port mem_ready_i, input, 1 bit, backing-memory completion, valid for one cycle.

Function
REQ-018 The cache SHALL be direct-mapped with one 32-bit word per line: addr_i[1:0] ignored, index addr_i[SET_BITS+1:2], tag = the remaining upper bits.
REQ-019 The cache SHALL be write-through and no-write-allocate.
REQ-020 The FSM SHALL have exactly three states: IDLE, FILL and WRITE.
REQ-021 In IDLE, a read hit (req_i=1, we_i=0, valid and tag match) SHALL drive rdata_o combinationally in the same cycle with stall_o=0, giving zero added latency.
REQ-022 In IDLE, a read miss SHALL raise stall_o combinationally that cycle and transition to FILL.
REQ-023 In FILL, mem_req_o=1 and mem_we_o=0 SHALL be held with the aligned address; on mem_ready_i the line SHALL be written from mem_rdata_i with valid set and tag stored, and the FSM SHALL return to IDLE.
REQ-024 stall_o SHALL remain high through the mem_ready_i cycle, so the retried access hits the cycle after.
REQ-025 In IDLE, any store SHALL raise stall_o and transition to WRITE.
REQ-026 In WRITE, mem_req_o=1, mem_we_o=1 and mem_wdata_o=wdata_i SHALL be held until mem_ready_i, then the FSM SHALL return to IDLE.
REQ-027 If a store hits, the cached word SHALL be updated in the same edge as mem_ready_i; a store miss SHALL leave the array untouched.
REQ-028 addr_i, we_i and wdata_i SHALL be latched on leaving IDLE; mem_* outputs SHALL come from the latched copy, independent of input changes during the stall.
REQ-029 mem_ready_i SHALL be ignored in IDLE.
REQ-030 flush_i in IDLE SHALL clear all valid bits in one cycle and take priority over a same-cycle req_i, which is treated as a miss on the next cycle.
REQ-031 flush_i outside IDLE SHALL be held pending and applied on the return to IDLE, after the fill/write completes.
REQ-032 rdata_o SHALL be 0 whenever the cycle is not a read hit.

Reset
REQ-033 Asserting rst SHALL, immediately and asynchronously, set the FSM to IDLE, clear all valid bits and the pending flush, and drive stall_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0 and rdata_o=0.
REQ-034 Reset during FILL or WRITE SHALL abandon the transaction; a late mem_ready_i SHALL be ignored.
REQ-035 Data array contents SHALL not be reset.

Structure
REQ-036 A shared package cache_pkg SHALL hold the state enum (IDLE, FILL, WRITE) and the tag/index width localparams derived from DATA_WIDTH and SET_BITS.
REQ-037 One sub-module, cache_array, SHALL hold tag/valid/data storage with a combinational read port, one synchronous write port and a flush-all input.

Verification
REQ-038 Scenario: after reset, load 0x40 with memory returning 0xDEADBEEF after 3 cycles -> stall_o high for 4 cycles, one mem_req_o read at 0x40, next-cycle rdata_o=0xDEADBEEF with stall_o=0.
REQ-039 Scenario: load 0x40 hit, then store 0x12345678 to 0x40 -> a memory write is issued, stall until ready, and a subsequent load returns 0x12345678 with no memory read.
REQ-040 Scenario: load 0x40 then load 0x60 (same index, different tag) -> both miss; 0x60 evicts 0x40; reload of 0x40 misses again.
REQ-041 Scenario: store miss to 0x80 -> a memory write is issued, and a following load of 0x80 misses (no allocate).
REQ-042 Scenario: flush_i asserted during FILL -> fill completes, then all lines are invalid; a load to a previously cached address misses.
REQ-043 Scenario: rst asserted mid-FILL with mem_ready_i pulsing a cycle later -> outputs go to 0 immediately, no line becomes valid, and the FSM is in IDLE.
